// File: rtl/vga_capture_pkg.sv
// Shared types for the VGA capture path: pixel colour, timing description
// and the lock-qualification states.
package vga_capture_pkg;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } color_t;

  typedef struct packed {
    int size;
    int fp;
    int sync;
    int bp;
  } vga_timing_t;

  typedef enum logic [1:0] {
    ST_UNLOCKED,
    ST_LINE_QUAL,
    ST_FRAME_QUAL,
    ST_LOCKED
  } vga_lock_state_t;

  function automatic int full_len(vga_timing_t t);
    return t.size + t.fp + t.sync + t.bp;
  endfunction

endpackage

// File: rtl/vga_period_meter.sv
// Edge-to-edge saturating position counter; grades each period length at
// the terminating event and optionally flags a missing event as a timeout.
module vga_period_meter
  import vga_capture_pkg::*;
#(
  parameter int FULL       = 1040,
  parameter bit TIMEOUT_EN = 1'b1,
  localparam int W         = $clog2(2*FULL+1)
) (
  input  logic         pixelclk,
  input  logic         rst,
  input  logic         evt_i,
  input  logic         tick_i,
  output logic [W-1:0] pos_o,
  output logic         period_ok_o,
  output logic         period_bad_o
);
  localparam int            LW       = W + 1;
  localparam logic [W-1:0]  POS_MAX  = W'(2*FULL);
  localparam logic [W-1:0]  POS_ONE  = W'(1);
  localparam logic [LW-1:0] LEN_FULL = LW'(FULL);
  localparam logic [LW-1:0] LEN_ONE  = LW'(1);

  logic [W-1:0]  pos_q, pos_d;
  logic [LW-1:0] len;
  logic          timeout;

  always_comb begin
    pos_d = pos_q;
    if (evt_i)                          pos_d = '0;
    else if (tick_i && pos_q != POS_MAX) pos_d = pos_q + POS_ONE;
  end

  always_ff @(posedge pixelclk or posedge rst) begin
    if (rst) pos_q <= '0;
    else     pos_q <= pos_d;
  end

  // pos_q holds the last sample of the closing period, so length is pos_q+1
  assign len          = {1'b0, pos_q} + LEN_ONE;
  assign timeout      = TIMEOUT_EN && !evt_i && tick_i && (pos_q == POS_MAX - POS_ONE);
  assign pos_o        = pos_d;
  assign period_ok_o  = evt_i && (len == LEN_FULL);
  assign period_bad_o = (evt_i && (len != LEN_FULL)) || timeout;

endmodule

// File: rtl/vga_capture.sv
// VGA receiver: recovers the raster from sampled syncs, qualifies the timing
// and emits coordinate + colour for each visible pixel once locked.
module vga_capture
  import vga_capture_pkg::*;
#(
  parameter int H_SIZE           = 800,
  parameter int V_SIZE           = 600,
  parameter int H_FP             = 56,
  parameter int H_SYNC           = 120,
  parameter int H_BP             = 64,
  parameter int V_FP             = 37,
  parameter int V_SYNC           = 6,
  parameter int V_BP             = 23,
  parameter int SYNC_ACTIVE_HIGH = 1,
  parameter int LOCK_LINES       = 16
) (
  input  logic                      pixelclk,
  input  logic                      rst,
  input  logic                      vga_hsync,
  input  logic                      vga_vsync,
  input  color_t                    color_in,
  output logic [$clog2(H_SIZE)-1:0] pix_x,
  output logic [$clog2(V_SIZE)-1:0] pix_y,
  output color_t                    color_out,
  output logic                      pix_valid,
  output logic                      frame_start,
  output logic                      locked,
  output logic                      timing_err
);
  localparam vga_timing_t HT = '{size: H_SIZE, fp: H_FP, sync: H_SYNC, bp: H_BP};
  localparam vga_timing_t VT = '{size: V_SIZE, fp: V_FP, sync: V_SYNC, bp: V_BP};
  localparam int FULL_H = full_len(HT);
  localparam int FULL_V = full_len(VT);
  localparam int HW     = $clog2(2*FULL_H+1);
  localparam int VW     = $clog2(2*FULL_V+1);
  localparam int XW     = $clog2(H_SIZE);
  localparam int YW     = $clog2(V_SIZE);
  localparam int CW     = $clog2(LOCK_LINES+1);
  localparam bit POL_HI = (SYNC_ACTIVE_HIGH != 0);
  localparam logic [HW-1:0] H_LO      = HW'(HT.bp);
  localparam logic [HW-1:0] H_HI      = HW'(HT.bp + HT.size);
  localparam logic [VW-1:0] V_LO      = VW'(VT.bp);
  localparam logic [VW-1:0] V_HI      = VW'(VT.bp + VT.size);
  localparam logic [CW-1:0] GOOD_LAST = CW'(LOCK_LINES-1);
  localparam logic [CW-1:0] GOOD_ONE  = CW'(1);

  logic            hs_n, vs_n;
  logic            hs_q, hs_prev_q, vs_q, vs_prev_q, v_pend_q, v_pend_d;
  color_t          col_q;
  logic            h_fall, v_fall, v_reset;
  logic [HW-1:0]   h_pos;
  logic [VW-1:0]   v_line;
  logic            h_ok, h_bad, v_ok, v_bad;

  assign hs_n = POL_HI ? vga_hsync : ~vga_hsync;
  assign vs_n = POL_HI ? vga_vsync : ~vga_vsync;

  always_ff @(posedge pixelclk or posedge rst) begin
    if (rst) begin
      hs_q      <= 1'b0;
      hs_prev_q <= 1'b0;
      vs_q      <= 1'b0;
      vs_prev_q <= 1'b0;
      v_pend_q  <= 1'b0;
      col_q     <= '0;
    end else begin
      hs_q      <= hs_n;
      hs_prev_q <= hs_q;
      vs_q      <= vs_n;
      vs_prev_q <= vs_q;
      v_pend_q  <= v_pend_d;
      col_q     <= color_in;
    end
  end

  // A vsync fall coinciding with an hsync fall is consumed on that same line start
  assign h_fall   = hs_prev_q & ~hs_q;
  assign v_fall   = vs_prev_q & ~vs_q;
  assign v_reset  = h_fall & (v_pend_q | v_fall);
  assign v_pend_d = ~v_reset & (v_pend_q | v_fall);

  vga_period_meter #(.FULL(FULL_H), .TIMEOUT_EN(1'b1)) u_hmeter (
    .pixelclk     (pixelclk),
    .rst          (rst),
    .evt_i        (h_fall),
    .tick_i       (1'b1),
    .pos_o        (h_pos),
    .period_ok_o  (h_ok),
    .period_bad_o (h_bad)
  );

  vga_period_meter #(.FULL(FULL_V), .TIMEOUT_EN(1'b0)) u_vmeter (
    .pixelclk     (pixelclk),
    .rst          (rst),
    .evt_i        (v_reset),
    .tick_i       (h_fall),
    .pos_o        (v_line),
    .period_ok_o  (v_ok),
    .period_bad_o (v_bad)
  );

  vga_lock_state_t state_q, state_d;
  logic [CW-1:0]   good_q, good_d;
  logic            arm_q, arm_d, err_q, err_d;

  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    arm_d   = arm_q;
    err_d   = 1'b0;
    unique case (state_q)
      ST_UNLOCKED: if (h_fall) begin
        good_d  = '0;
        state_d = ST_LINE_QUAL;
      end
      ST_LINE_QUAL: begin
        if (h_bad) good_d = '0;
        else if (h_ok) begin
          if (good_q == GOOD_LAST) begin
            state_d = ST_FRAME_QUAL;
            arm_d   = 1'b0;
          end else begin
            good_d = good_q + GOOD_ONE;
          end
        end
      end
      // First vertical reset only arms so the graded frame lies wholly inside qualification
      ST_FRAME_QUAL: begin
        if (h_bad) begin
          good_d  = '0;
          state_d = ST_LINE_QUAL;
        end else if (v_reset) begin
          if (arm_q && v_ok) state_d = ST_LOCKED;
          arm_d = 1'b1;
        end
      end
      ST_LOCKED: if (h_bad || v_bad) begin
        err_d   = 1'b1;
        state_d = ST_UNLOCKED;
      end
      default: state_d = ST_UNLOCKED;
    endcase
  end

  always_ff @(posedge pixelclk or posedge rst) begin
    if (rst) begin
      state_q <= ST_UNLOCKED;
      good_q  <= '0;
      arm_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      good_q  <= good_d;
      arm_q   <= arm_d;
      err_q   <= err_d;
    end
  end

  logic          act_d;
  logic [XW-1:0] x_d;
  logic [YW-1:0] y_d;
  logic          pix_valid_q, frame_start_q;
  logic [XW-1:0] pix_x_q;
  logic [YW-1:0] pix_y_q;
  color_t        color_out_q;

  always_comb begin
    act_d = (h_pos >= H_LO) && (h_pos < H_HI) && (v_line >= V_LO) && (v_line < V_HI)
            && (state_q == ST_LOCKED);
    x_d   = '0;
    y_d   = '0;
    if (act_d) begin
      x_d = XW'(h_pos - H_LO);
      y_d = YW'(v_line - V_LO);
    end
  end

  always_ff @(posedge pixelclk or posedge rst) begin
    if (rst) begin
      pix_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      color_out_q   <= '0;
    end else begin
      pix_valid_q   <= act_d;
      frame_start_q <= act_d && (x_d == '0) && (y_d == '0);
      pix_x_q       <= x_d;
      pix_y_q       <= y_d;
      color_out_q   <= act_d ? col_q : '0;
    end
  end

  assign pix_valid   = pix_valid_q;
  assign frame_start = frame_start_q;
  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign color_out   = color_out_q;
  assign locked      = (state_q == ST_LOCKED);
  assign timing_err  = err_q;

endmodule

// File: doc/vga_capture.md
Name: vga_capture

Overview:
- Receiver counterpart of the VGA timing generator: samples vga_hsync, vga_vsync and color_in on pixelclk.
- Recovers the pixel raster and outputs the coordinate and colour of every visible pixel with a valid strobe.
- Qualifies the incoming timing before reporting lock.
- Sits between a VGA source (or the generator in loopback) and a frame buffer / checker.
- Sources share pixelclk; no CDC inside.

Parameters:
H_SIZE, 800, visible pixels per line
V_SIZE, 600, visible lines per frame
H_FP, 56, horizontal front porch (pixels)
H_SYNC, 120, horizontal sync width (pixels)
H_BP, 64, horizontal back porch (pixels)
V_FP, 37, vertical front porch (lines)
V_SYNC, 6, vertical sync width (lines)
V_BP, 23, vertical back porch (lines)
SYNC_ACTIVE_HIGH, 1, sync polarity; 0 inverts both sync inputs at sampling
LOCK_LINES, 16, consecutive correct lines required before frame qualification

Ports:
pixelclk  in  1  pixel clock
rst  in  1  reset, asynchronous, active-high
vga_hsync  in  1  horizontal sync
vga_vsync  in  1  vertical sync
color_in  in  color_t  sampled pixel colour
pix_x  out  $clog2(H_SIZE)  x of captured pixel
pix_y  out  $clog2(V_SIZE)  y of captured pixel
color_out  out  color_t  captured colour
pix_valid  out  1  pix_x/pix_y/color_out valid this cycle
frame_start  out  1  one-cycle pulse with pixel (0,0)
locked  out  1  timing qualified
timing_err  out  1  one-cycle pulse on any timing violation

Behaviour:
- Derived constants: FullH = H_SIZE+H_FP+H_SYNC+H_BP (1040), FullV = V_SIZE+V_FP+V_SYNC+V_BP (666).
- Input register stage: hs_q, vs_q, col_q sampled every cycle. Polarity is normalised to active-high before sampling.
- Horizontal:
  - h_fall = hs_q_prev & ~hs_q.
  - On h_fall, h_pos := 0; otherwise h_pos increments.
  - h_pos saturates at FullH*2 and never wraps.
  - The sample at h_fall is the first back-porch pixel.
- Line length check:
  - On each h_fall, the previous h_pos+1 is compared against FullH.
  - The first h_fall after reset/unlock only starts measurement.
- Vertical:
  - v_fall (same form on vs_q) sets v_pend.
  - At the next h_fall with v_pend set: v_line := 0 and v_pend clears; otherwise v_line increments on each h_fall.
  - v_line saturates at FullV*2.
  - Frame length = v_line+1 at the resetting h_fall, compared against FullV.
- Active region: h_pos in [H_BP, H_BP+H_SIZE) and v_line in [V_BP, V_BP+V_SIZE).
- Outputs, registered, 1 cycle after the col_q sample:
  - pix_valid = active & locked; pix_x = h_pos-H_BP; pix_y = v_line-V_BP; color_out = col_q.
  - When not valid: pix_x=0, pix_y=0, color_out='0.
  - frame_start = pix_valid & pix_x==0 & pix_y==0.
- Lock FSM:
  - UNLOCKED: wait for the first h_fall, clear good-line counter, go to LINE_QUAL.
  - LINE_QUAL: good line increments the counter; bad line resets it to 0 and stays in LINE_QUAL. Counter reaching LOCK_LINES goes to FRAME_QUAL.
  - FRAME_QUAL: bad line goes to LINE_QUAL. The first vertical reset only arms. A second vertical reset with frame length == FullV goes to LOCKED; otherwise stay, re-armed.
  - LOCKED: any bad line or bad frame pulses timing_err and goes to UNLOCKED.
- Timeout: h_pos reaching 2*FullH (no hsync) counts as a bad line in every state except UNLOCKED; in LOCKED it also pulses timing_err.
- locked = (state==LOCKED). It deasserts in the same cycle as the timing_err pulse; pix_valid is 0 from then on.
- Simultaneous h_fall and v_fall in one sample: v_pend is set and consumed on that same h_fall, so v_line := 0.
- Reset: async, mid-operation included. All counters 0, state UNLOCKED, v_pend 0, all outputs 0.
- Width rules:
  - h_pos and v_line are $clog2(2*FullH+1) and $clog2(2*FullV+1) bits.
  - Subtractions are performed only inside the active region, so there is no underflow.

Decomposition:
- pkg: color_t (existing); add vga_timing_t struct (size/fp/sync/bp) and lock FSM enum vga_lock_state_t.
- Sub-module vga_period_meter: edge-to-edge saturating counter with compare, instantiated twice (horizontal on h_fall in pixels, vertical on v-reset in lines). Outputs period_ok, period_bad and pos.

Test Plan:
- Loopback to the vga generator with defaults, after reset: locked rises after 16 lines plus ≤2 frames. Then exactly 480000 pix_valid per frame, one frame_start per 1040*666 cycles, and color_out matches the generator's colour for every (x,y).
- Lock loss: while locked, stretch one line to 1041 cycles -> timing_err pulses once, locked=0 the same cycle, pix_valid stays 0 until requalified.
- Sync loss: hold hsync inactive for 2080 cycles while locked -> timing_err pulse and unlock; restore -> relock.
- Polarity: SYNC_ACTIVE_HIGH=0 with inverted generator syncs -> identical pix_x/pix_y/color_out stream as the first scenario.
- Wrong frame length: 665-line frames -> never locks, FSM stays in FRAME_QUAL, timing_err stays 0.
- Async rst asserted mid-line while locked -> all outputs 0 immediately; after release, lock re-acquired as in the first scenario.
